// File: rtl/wave_sequencer_if.sv
// Control/config bundle between a sequencing master and wave_sequencer.
// The master programs the step table and controls runs; the sequencer reports status.
interface wave_sequencer_if #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [DWELL_W+1:0] cfg_data;
    logic [AW-1:0]     num_steps;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic [1:0]        wave_choise;
    logic              busy;
    logic [AW-1:0]     step_idx;
    logic              step_pulse;
    logic              done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, num_steps, loop_en, start, stop,
        input  wave_choise, busy, step_idx, step_pulse, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, num_steps, loop_en, start, stop,
        output wave_choise, busy, step_idx, step_pulse, done
    );
endinterface

// File: rtl/wave_sequencer.sv
// Programmable step-table sequencer driving signal_generator's 2-bit waveform select.
// Each step is {choice, dwell}; a step lasts dwell+1 cycles, run once or looped.
module wave_sequencer #(
    parameter int          DEPTH       = 4,
    parameter int          DWELL_W     = 8,
    parameter logic [1:0]  IDLE_CHOICE = 2'b00
) (
    input  logic           clk,
    input  logic           rst_n,
    wave_sequencer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = DWELL_W + 2;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              state;
    logic [EW-1:0]       entry_q [DEPTH];
    logic [DWELL_W-1:0]  cnt;
    logic [AW-1:0]       last;
    logic [1:0]          choice_q;
    logic                busy_q;
    logic [AW-1:0]       idx_q;
    logic                pulse_q;
    logic                done_q;

    logic [AW-1:0]       next_idx;
    logic [EW-1:0]       next_entry;

    function automatic logic [1:0] entry_choice(input logic [EW-1:0] e);
        return e[EW-1:DWELL_W];
    endfunction

    function automatic logic [DWELL_W-1:0] entry_dwell(input logic [EW-1:0] e);
        return e[DWELL_W-1:0];
    endfunction

    // Step table; writes land any time and only matter when an entry is next loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            entry_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Index of the entry loaded at the next segment boundary: 0 on start or wrap.
    always_comb begin
        next_idx = '0;
        if (state == ST_RUN && idx_q != last) begin
            next_idx = idx_q + 1'b1;
        end
        next_entry = entry_q[next_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last     <= '0;
            choice_q <= IDLE_CHOICE;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        last     <= bus.num_steps;
                        idx_q    <= '0;
                        choice_q <= entry_choice(next_entry);
                        cnt      <= entry_dwell(next_entry);
                        busy_q   <= 1'b1;
                        pulse_q  <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        // Abort wins over any segment boundary in the same cycle.
                        choice_q <= IDLE_CHOICE;
                        busy_q   <= 1'b0;
                        idx_q    <= '0;
                        cnt      <= '0;
                        state    <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (idx_q != last || bus.loop_en) begin
                        idx_q    <= next_idx;
                        choice_q <= entry_choice(next_entry);
                        cnt      <= entry_dwell(next_entry);
                        pulse_q  <= 1'b1;
                    end else begin
                        choice_q <= IDLE_CHOICE;
                        busy_q   <= 1'b0;
                        idx_q    <= '0;
                        done_q   <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wave_choise = choice_q;
    assign bus.busy        = busy_q;
    assign bus.step_idx    = idx_q;
    assign bus.step_pulse  = pulse_q;
    assign bus.done        = done_q;

endmodule
